voice_allocator: RTL and testbench

- Sits between the MIDI parser and the synth voice engine; owns the mapping of (channel, note) to voice slot addresses.
- For each incoming note-on, note-off or key-pressure event it picks a voice slot and replays the event with a slot address in the same cycle:
  - note-on: retrigger the matching slot, else the first free slot, else steal round-robin.
  - note-off / key-pressure: the matching slot only.
- Slots are freed when the voice engine reports end-of-release on voice_done / voice_done_addr.

---
 rtl/voice_allocator_if.sv | 45 ++++
 rtl/voice_allocator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// Event request / voice-engine bus between MIDI parser, voice allocator and synth voice engine.
// Pure wiring, no latency of its own.
// ready qualifies requests; the engine side has no backpressure (pulses are fire-and-forget).
interface voice_allocator_if #(
  parameter int ADDR_W = 8
);
  // Request side (MIDI parser)
  logic              ev_on;
  logic              ev_off;
  logic              ev_kp;
  logic [6:0]        ev_note;
  logic [6:0]        ev_velocity;
  logic [3:0]        ev_channel;
  logic              ready;
  logic              dropped;
  // Voice engine side
  logic              voice_done;
  logic [ADDR_W-1:0] voice_done_addr;
  logic              note_pressed;
  logic              note_released;
  logic              note_keypress;
  logic [6:0]        note_o;
  logic [6:0]        velocity_o;
  logic [3:0]        channel_o;
  logic [ADDR_W-1:0] addr;
  logic              stolen;

  // Parser + voice engine view: drives requests and done reports.
  modport master (
    output ev_on, ev_off, ev_kp, ev_note, ev_velocity, ev_channel,
    output voice_done, voice_done_addr,
    input  ready, dropped,
    input  note_pressed, note_released, note_keypress,
    input  note_o, velocity_o, channel_o, addr, stolen
  );

  // Allocator view.
  modport slave (
    input  ev_on, ev_off, ev_kp, ev_note, ev_velocity, ev_channel,
    input  voice_done, voice_done_addr,
    output ready, dropped,
    output note_pressed, note_released, note_keypress,
    output note_o, velocity_o, channel_o, addr, stolen
  );
endinterface

// File: rtl/voice_allocator.sv
// Maps (channel, note) events onto voice slots: retrigger / first-free / round-robin steal.
// Output pulse in the cycle starting N_VOICES+2 edges after the accepting edge.
// One request in flight; ready=0 while busy, requests seen with ready=0 are dropped.
module voice_allocator #(
  parameter int N_VOICES = 256,
  parameter int ADDR_W   = 8
) (
  input logic               clk,
  input logic               rst,
  voice_allocator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, ISSUE} state_t;
  typedef enum logic [1:0] {K_ON, K_OFF, K_KP} kind_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_VOICES - 1);

  // Tag table: valid bits are resettable flops, channel/note are plain storage.
  logic [N_VOICES-1:0] valid_q, valid_d;
  logic [3:0]          tag_ch_mem   [N_VOICES];
  logic [6:0]          tag_note_mem [N_VOICES];

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic              ready_q, ready_d;
  logic              dropped_q, dropped_d;
  logic              pressed_q, pressed_d;
  logic              released_q, released_d;
  logic              keypress_q, keypress_d;
  logic              stolen_q, stolen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        note_q, note_d;
  logic [6:0]        vel_q, vel_d;
  logic [3:0]        chan_q, chan_d;
  logic              drain_q, drain_d;
  // Scan pipeline: read index, then the registered read result.
  logic [ADDR_W-1:0] scan_idx_q, scan_idx_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              rd_tag_vld_q, rd_tag_vld_d;
  logic [3:0]        rd_ch_q, rd_ch_d;
  logic [6:0]        rd_note_q, rd_note_d;
  // Match / free trackers.
  logic              m_found_q, m_found_d;
  logic [ADDR_W-1:0] m_idx_q, m_idx_d;
  logic              f_found_q, f_found_d;
  logic [ADDR_W-1:0] f_idx_q, f_idx_d;
  logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
  // Decision held between RESOLVE and ISSUE.
  logic              dec_press_q, dec_press_d;
  logic              dec_rel_q, dec_rel_d;
  logic              dec_kp_q, dec_kp_d;
  logic              dec_stolen_q, dec_stolen_d;
  logic [ADDR_W-1:0] dec_addr_q, dec_addr_d;
  // Deferred voice_done clear.
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              ev_any, accept, hit_match, hit_free;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  assign ev_any = bus.ev_on | bus.ev_off | bus.ev_kp;
  assign accept = ready_q & ev_any;

  // Next-state: request capture, scan sequencing, tracker merge, decision, tag write and done clears.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    ready_d      = ready_q;
    dropped_d    = ~ready_q & ev_any;
    pressed_d    = 1'b0;
    released_d   = 1'b0;
    keypress_d   = 1'b0;
    stolen_d     = 1'b0;
    addr_d       = addr_q;
    note_d       = note_q;
    vel_d        = vel_q;
    chan_d       = chan_q;
    drain_d      = 1'b0;
    scan_idx_d   = scan_idx_q;
    rd_vld_d     = 1'b0;
    rd_idx_d     = rd_idx_q;
    rd_tag_vld_d = rd_tag_vld_q;
    rd_ch_d      = rd_ch_q;
    rd_note_d    = rd_note_q;
    rr_ptr_d     = rr_ptr_q;
    dec_press_d  = dec_press_q;
    dec_rel_d    = dec_rel_q;
    dec_kp_d     = dec_kp_q;
    dec_stolen_d = dec_stolen_q;
    dec_addr_d   = dec_addr_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    valid_d      = valid_q;

    // Fold the tag returned this cycle into the trackers (lowest index wins).
    hit_match = rd_vld_q & rd_tag_vld_q & (rd_ch_q == chan_q) & (rd_note_q == note_q);
    hit_free  = rd_vld_q & ~rd_tag_vld_q;
    m_found_d = m_found_q | hit_match;
    m_idx_d   = (!m_found_q && hit_match) ? rd_idx_q : m_idx_q;
    f_found_d = f_found_q | hit_free;
    f_idx_d   = (!f_found_q && hit_free) ? rd_idx_q : f_idx_q;

    unique case (state_q)
      IDLE: begin
        if (drain_q) ready_d = 1'b1;
        if (accept) begin
          state_d    = SCAN;
          ready_d    = 1'b0;
          note_d     = bus.ev_note;
          vel_d      = bus.ev_velocity;
          chan_d     = bus.ev_channel;
          kind_d     = bus.ev_on ? K_ON : (bus.ev_off ? K_OFF : K_KP);
          scan_idx_d = '0;
          m_found_d  = 1'b0;
          f_found_d  = 1'b0;
        end
      end
      SCAN: begin
        rd_vld_d     = 1'b1;
        rd_idx_d     = scan_idx_q;
        rd_tag_vld_d = valid_q[scan_idx_q];
        rd_ch_d      = tag_ch_mem[scan_idx_q];
        rd_note_d    = tag_note_mem[scan_idx_q];
        scan_idx_d   = scan_idx_q + 1'b1;
        if (scan_idx_q == LAST_IDX) state_d = RESOLVE;
      end
      RESOLVE: begin
        dec_press_d  = 1'b0;
        dec_rel_d    = 1'b0;
        dec_kp_d     = 1'b0;
        dec_stolen_d = 1'b0;
        if (kind_q == K_ON) begin
          dec_press_d = 1'b1;
          if (m_found_d) begin
            dec_addr_d = m_idx_d;
          end else if (f_found_d) begin
            dec_addr_d = f_idx_d;
            wr_en      = 1'b1;
            wr_addr    = f_idx_d;
          end else begin
            dec_addr_d   = rr_ptr_q;
            dec_stolen_d = 1'b1;
            wr_en        = 1'b1;
            wr_addr      = rr_ptr_q;
            rr_ptr_d     = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + 1'b1;
          end
        end else if (m_found_d) begin
          dec_addr_d = m_idx_d;
          dec_rel_d  = (kind_q == K_OFF);
          dec_kp_d   = (kind_q == K_KP);
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        pressed_d  = dec_press_q;
        released_d = dec_rel_q;
        keypress_d = dec_kp_q;
        stolen_d   = dec_stolen_q;
        if (dec_press_q | dec_rel_q | dec_kp_q) addr_d = dec_addr_q;
        drain_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) valid_d[wr_addr] = 1'b1;

    // Done clears share the single write port; an allocation write wins and the
    // clear is parked for one cycle unless it targets the slot just written.
    clr_en      = bus.voice_done | pend_vld_q;
    clr_addr    = bus.voice_done ? bus.voice_done_addr : pend_addr_q;
    pend_vld_d  = 1'b0;
    pend_addr_d = pend_addr_q;
    if (clr_en) begin
      if (wr_en) begin
        if (clr_addr != wr_addr) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = clr_addr;
        end
      end else if (int'(clr_addr) < N_VOICES) begin
        valid_d[clr_addr] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      kind_q       <= K_ON;
      ready_q      <= 1'b1;
      dropped_q    <= 1'b0;
      pressed_q    <= 1'b0;
      released_q   <= 1'b0;
      keypress_q   <= 1'b0;
      stolen_q     <= 1'b0;
      addr_q       <= '0;
      note_q       <= '0;
      vel_q        <= '0;
      chan_q       <= '0;
      drain_q      <= 1'b0;
      scan_idx_q   <= '0;
      rd_vld_q     <= 1'b0;
      rd_idx_q     <= '0;
      rd_tag_vld_q <= 1'b0;
      rd_ch_q      <= '0;
      rd_note_q    <= '0;
      m_found_q    <= 1'b0;
      m_idx_q      <= '0;
      f_found_q    <= 1'b0;
      f_idx_q      <= '0;
      rr_ptr_q     <= '0;
      dec_press_q  <= 1'b0;
      dec_rel_q    <= 1'b0;
      dec_kp_q     <= 1'b0;
      dec_stolen_q <= 1'b0;
      dec_addr_q   <= '0;
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      ready_q      <= ready_d;
      dropped_q    <= dropped_d;
      pressed_q    <= pressed_d;
      released_q   <= released_d;
      keypress_q   <= keypress_d;
      stolen_q     <= stolen_d;
      addr_q       <= addr_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
      chan_q       <= chan_d;
      drain_q      <= drain_d;
      scan_idx_q   <= scan_idx_d;
      rd_vld_q     <= rd_vld_d;
      rd_idx_q     <= rd_idx_d;
      rd_tag_vld_q <= rd_tag_vld_d;
      rd_ch_q      <= rd_ch_d;
      rd_note_q    <= rd_note_d;
      m_found_q    <= m_found_d;
      m_idx_q      <= m_idx_d;
      f_found_q    <= f_found_d;
      f_idx_q      <= f_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      dec_press_q  <= dec_press_d;
      dec_rel_q    <= dec_rel_d;
      dec_kp_q     <= dec_kp_d;
      dec_stolen_q <= dec_stolen_d;
      dec_addr_q   <= dec_addr_d;
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
      valid_q      <= valid_d;
    end
  end

  // Tag channel/note storage; meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tag_ch_mem[wr_addr]   <= chan_q;
      tag_note_mem[wr_addr] <= note_q;
    end
  end

  assign bus.ready         = ready_q;
  assign bus.dropped       = dropped_q;
  assign bus.note_pressed  = pressed_q;
  assign bus.note_released = released_q;
  assign bus.note_keypress = keypress_q;
  assign bus.stolen        = stolen_q;
  assign bus.addr          = addr_q;
  assign bus.note_o        = note_q;
  assign bus.velocity_o    = vel_q;
  assign bus.channel_o     = chan_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator with 4 voices: vector table, hand sequences, random vs slot model.
// Each event checked at its fixed pulse slot, N_VOICES+2 edges after acceptance.
// Covers dropped requests, coincident done clears and reset mid-scan.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_allocator_if #(.ADDR_W(AW)) bus();
  voice_allocator #(.N_VOICES(NV), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // pulse codes: 0 none, 1 pressed, 2 released, 3 keypress, 9 several at once
  function automatic int pcode();
    int n;
    n = int'(bus.note_pressed) + int'(bus.note_released) + int'(bus.note_keypress);
    if (n > 1) return 9;
    if (bus.note_pressed) return 1;
    if (bus.note_released) return 2;
    if (bus.note_keypress) return 3;
    return 0;
  endfunction

  // Behavioural slot model: plain arrays, decided straight from the allocation rules.
  bit m_vld [NV];
  int m_ch  [NV];
  int m_note[NV];
  int m_rr;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_vld[i] = 0;
    m_rr = 0;
  endtask

  task automatic model_ev(input int kind, input int ch, input int note,
                          output int pulse, output int a, output int st);
    int mi, fi;
    mi = -1; fi = -1; pulse = 0; a = 0; st = 0;
    for (int i = 0; i < NV; i++) begin
      if (mi < 0 && m_vld[i] && m_ch[i] == ch && m_note[i] == note) mi = i;
      if (fi < 0 && !m_vld[i]) fi = i;
    end
    if (kind == 0) begin
      pulse = 1;
      if (mi >= 0) a = mi;
      else begin
        if (fi >= 0) a = fi;
        else begin
          a = m_rr; st = 1; m_rr = (m_rr + 1) % NV;
        end
        m_vld[a] = 1; m_ch[a] = ch; m_note[a] = note;
      end
    end else if (mi >= 0) begin
      pulse = (kind == 1) ? 2 : 3;
      a = mi;
    end
  endtask

  // One request: accept, watch the quiet scan, sample at the pulse slot and one cycle later.
  task automatic send(input int kind, input int ch, input int note, input int vel, input int done_addr,
                      output int pulse, output int a, output int st, output int mid_bad,
                      output int rdy_pulse, output int rdy_after, output int n_o, output int v_o, output int c_o);
    @(negedge clk);
    bus.ev_on = (kind == 0); bus.ev_off = (kind == 1); bus.ev_kp = (kind == 2);
    bus.ev_note = 7'(note); bus.ev_velocity = 7'(vel); bus.ev_channel = 4'(ch);
    @(negedge clk);
    bus.ev_on = 1'b0; bus.ev_off = 1'b0; bus.ev_kp = 1'b0;
    mid_bad = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 5 && done_addr >= 0) begin
        bus.voice_done = 1'b1; bus.voice_done_addr = AW'(done_addr);
      end
      if (k == 6) bus.voice_done = 1'b0;
      @(negedge clk);
      if (k < 6 && (pcode() != 0 || bus.stolen || bus.ready)) mid_bad++;
    end
    pulse = pcode(); a = int'(bus.addr); st = int'(bus.stolen); rdy_pulse = int'(bus.ready);
    n_o = int'(bus.note_o); v_o = int'(bus.velocity_o); c_o = int'(bus.channel_o);
    @(negedge clk);
    rdy_after = int'(bus.ready);
    if (pcode() != 0) mid_bad++;
  endtask

  task automatic done_pulse(input int a);
    @(negedge clk);
    bus.voice_done = 1'b1; bus.voice_done_addr = AW'(a);
    @(negedge clk);
    bus.voice_done = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int kind; int ch; int note; int vel;
    int pulse; int addr; int st;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int p, a, s, mb, rp, ra, no, vo, co, viol, ep, ea, es;

    tbl[0]  = '{0, 0, 60, 100, 1, 0, 0};
    tbl[1]  = '{0, 0, 60,  90, 1, 0, 0};
    tbl[2]  = '{1, 0, 60,   0, 2, 0, 0};
    tbl[3]  = '{1, 1, 60,   0, 0, 0, 0};
    tbl[4]  = '{2, 0, 60,  33, 3, 0, 0};
    tbl[5]  = '{0, 0, 61,  50, 1, 1, 0};
    tbl[6]  = '{0, 0, 62,  51, 1, 2, 0};
    tbl[7]  = '{0, 0, 63,  52, 1, 3, 0};
    tbl[8]  = '{0, 0, 64,  53, 1, 0, 1};
    tbl[9]  = '{0, 0, 65,  54, 1, 1, 1};
    tbl[10] = '{1, 0, 60,   0, 0, 0, 0};
    tbl[11] = '{2, 0, 64,  77, 3, 0, 0};
    tbl[12] = '{0, 1, 63,  20, 1, 2, 1};

    rst = 1'b1;
    bus.ev_on = 1'b0; bus.ev_off = 1'b0; bus.ev_kp = 1'b0;
    bus.ev_note = '0; bus.ev_velocity = '0; bus.ev_channel = '0;
    bus.voice_done = 1'b0; bus.voice_done_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_pulses", int'({bus.note_pressed, bus.note_released, bus.note_keypress, bus.stolen, bus.dropped}), 0);
    chk("rst_data", int'({bus.addr, bus.note_o, bus.velocity_o, bus.channel_o}), 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      send(tbl[i].kind, tbl[i].ch, tbl[i].note, tbl[i].vel, -1, p, a, s, mb, rp, ra, no, vo, co);
      chk($sformatf("tbl%0d_pulse", i), p, tbl[i].pulse);
      chk($sformatf("tbl%0d_stolen", i), s, tbl[i].st);
      chk($sformatf("tbl%0d_quiet", i), mb, 0);
      chk($sformatf("tbl%0d_rdy_pulse", i), rp, 0);
      chk($sformatf("tbl%0d_rdy_after", i), ra, 1);
      if (tbl[i].pulse != 0) begin
        chk($sformatf("tbl%0d_addr", i), a, tbl[i].addr);
        chk($sformatf("tbl%0d_note", i), no, tbl[i].note);
        chk($sformatf("tbl%0d_vel", i), vo, tbl[i].vel);
        chk($sformatf("tbl%0d_ch", i), co, tbl[i].ch);
      end
    end

    // slots now: 0=ch0/64 1=ch0/65 2=ch1/63 3=ch0/63, rr=3
    done_pulse(2);
    send(0, 0, 70, 40, -1, p, a, s, mb, rp, ra, no, vo, co);
    chk("free_after_done_pulse", p, 1); chk("free_after_done_addr", a, 2); chk("free_after_done_st", s, 0);

    // done on slot 3 coincident with the write allocating slot 3: tag must survive
    done_pulse(3);
    send(0, 2, 80, 41, 3, p, a, s, mb, rp, ra, no, vo, co);
    chk("coinc_same_addr", a, 3); chk("coinc_same_st", s, 0);
    send(1, 2, 80, 0, -1, p, a, s, mb, rp, ra, no, vo, co);
    chk("coinc_same_off_pulse", p, 2); chk("coinc_same_off_addr", a, 3);

    // done on slot 0 coincident with a write to slot 3: clear deferred, then applied
    done_pulse(3);
    send(0, 2, 81, 42, 0, p, a, s, mb, rp, ra, no, vo, co);
    chk("coinc_other_addr", a, 3);
    send(0, 3, 82, 43, -1, p, a, s, mb, rp, ra, no, vo, co);
    chk("pending_clear_addr", a, 0); chk("pending_clear_st", s, 0);

    // request while busy is dropped; slots full (0=82 1=65 2=70 3=81), rr=3
    @(negedge clk);
    bus.ev_on = 1'b1; bus.ev_note = 7'd90; bus.ev_velocity = 7'd9; bus.ev_channel = 4'd0;
    @(negedge clk);
    bus.ev_on = 1'b0;
    @(negedge clk);
    bus.ev_kp = 1'b1;
    @(negedge clk);
    bus.ev_kp = 1'b0;
    chk("dropped_pulse", int'(bus.dropped), 1);
    @(negedge clk);
    chk("dropped_clears", int'(bus.dropped), 0);
    repeat (3) @(negedge clk);
    chk("drop_orig_pulse", pcode(), 1);
    chk("drop_orig_addr", int'(bus.addr), 3);
    chk("drop_orig_st", int'(bus.stolen), 1);
    viol = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pcode() != 0) viol++;
    end
    chk("drop_no_extra_event", viol, 0);

    // reset in the middle of a scan
    @(negedge clk);
    bus.ev_on = 1'b1; bus.ev_note = 7'd91; bus.ev_velocity = 7'd5; bus.ev_channel = 4'd0;
    @(negedge clk);
    bus.ev_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      if (pcode() != 0 || !bus.ready) viol++;
      @(negedge clk);
    end
    chk("rst_midscan_quiet", viol, 0);
    send(0, 5, 10, 11, -1, p, a, s, mb, rp, ra, no, vo, co);
    chk("post_rst_pulse", p, 1); chk("post_rst_addr", a, 0); chk("post_rst_st", s, 0);

    // random traffic against the slot model
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 60; i++) begin
      int r, kind, ch, note, vel;
      r = int'($urandom_range(9));
      if (r < 2) begin
        int da;
        da = int'($urandom_range(NV - 1));
        m_vld[da] = 0;
        done_pulse(da);
      end else begin
        kind = (r < 6) ? 0 : int'($urandom_range(2));
        ch   = int'($urandom_range(1));
        note = 60 + int'($urandom_range(2));
        vel  = int'($urandom_range(127));
        model_ev(kind, ch, note, ep, ea, es);
        send(kind, ch, note, vel, -1, p, a, s, mb, rp, ra, no, vo, co);
        chk($sformatf("rnd%0d_pulse", i), p, ep);
        chk($sformatf("rnd%0d_stolen", i), s, es);
        chk($sformatf("rnd%0d_ready", i), ra, 1);
        if (ep != 0) chk($sformatf("rnd%0d_addr", i), a, ea);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
